// File: rtl/adder_client.sv
// adder_client: buffers producer words in a FIFO and replays them as an
// AXI-Stream master into the adder, counting accepted beats and packets.
module adder_client #(
   parameter int DATAW      = 128,
   parameter int FIFO_DEPTH = 16,
   parameter int CNTW       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATAW-1:0]              client_tdata,
   input  logic                          client_tlast,
   input  logic                          client_valid,
   output logic                          client_ready,
   output logic                          axis_adder_interface_tvalid,
   output logic                          axis_adder_interface_tlast,
   output logic [DATAW-1:0]              axis_adder_interface_tdata,
   input  logic                          axis_adder_interface_tready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_occupancy,
   output logic [CNTW-1:0]               beat_count,
   output logic [CNTW-1:0]               pkt_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     P1 = 1;
   localparam logic [CNTW-1:0] C1 = 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [DATAW:0]  mem_q [FIFO_DEPTH];
   logic [AW:0]     wptr_q, rptr_q;
   logic [DATAW:0]  out_q;
   logic [CNTW-1:0] beat_q, pkt_q;
   logic            empty, full, push, pop, hs;

   assign empty = wptr_q == rptr_q;
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push  = client_valid && !full;
   assign hs    = (state_q == SEND) && axis_adder_interface_tready;

   assign client_ready                = !full;
   assign fifo_occupancy              = wptr_q - rptr_q;
   assign axis_adder_interface_tvalid = state_q == SEND;
   assign axis_adder_interface_tlast  = out_q[DATAW];
   assign axis_adder_interface_tdata  = out_q[DATAW-1:0];
   assign beat_count                  = beat_q;
   assign pkt_count                   = pkt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // The output register may be refilled whenever it is empty or its beat is taken.
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE || axis_adder_interface_tready) state_d = empty ? IDLE : SEND;
   end

   always_comb begin
      pop = (state_q == IDLE || axis_adder_interface_tready) && !empty;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= {client_tlast, client_tdata};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         out_q  <= '0;
         beat_q <= '0;
         pkt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + P1;
         if (pop) begin
            rptr_q <= rptr_q + P1;
            out_q  <= mem_q[rptr_q[AW-1:0]];
         end
         if (hs) beat_q <= beat_q + C1;
         if (hs && out_q[DATAW]) pkt_q <= pkt_q + C1;
      end
   end
endmodule

// File: tb/tb_adder_client.sv
// tb_adder_client: randomized bench for adder_client against a queue-level
// model of the buffered stream (FIFO contents plus one pending output beat).
module tb_adder_client;
   localparam int DATAW = 128;
   localparam int DEPTH = 16;
   localparam int CNTW  = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [DATAW-1:0] client_tdata = '0;
   logic             client_tlast = 1'b0;
   logic             client_valid = 1'b0;
   logic             client_ready;
   logic             tvalid, tlast, tready = 1'b0;
   logic [DATAW-1:0] tdata;
   logic [4:0]       occ;
   logic [CNTW-1:0]  beat_count, pkt_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATAW:0]  mq[$];
   logic [DATAW:0]  m_out = '0;
   logic            m_valid = 1'b0;
   logic [CNTW-1:0] m_beats = '0, m_pkts = '0;
   logic            accepted;

   adder_client #(.DATAW(DATAW), .FIFO_DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .clk(clk),
      .rst(rst),
      .client_tdata(client_tdata),
      .client_tlast(client_tlast),
      .client_valid(client_valid),
      .client_ready(client_ready),
      .axis_adder_interface_tvalid(tvalid),
      .axis_adder_interface_tlast(tlast),
      .axis_adder_interface_tdata(tdata),
      .axis_adder_interface_tready(tready),
      .fifo_occupancy(occ),
      .beat_count(beat_count),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATAW:0] got, input logic [DATAW:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATAW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Advance the model by one clock using the inputs driven now, then compare.
   task automatic cycle();
      logic             hs, ld, stall;
      logic [DATAW-1:0] pre;
      hs    = m_valid && tready;
      accepted = client_valid && (mq.size() < DEPTH);
      ld    = (!m_valid || hs) && mq.size() > 0;
      stall = tvalid && !tready;
      pre   = tdata;
      if (hs) begin
         m_beats++;
         if (m_out[DATAW]) m_pkts++;
      end
      if (ld) begin
         m_out   = mq.pop_front();
         m_valid = 1'b1;
      end else if (hs) m_valid = 1'b0;
      if (accepted) mq.push_back({client_tlast, client_tdata});
      @(posedge clk);
      @(negedge clk);
      chk("tvalid", tvalid, m_valid);
      if (m_valid) begin
         chk("tdata", tdata, m_out[DATAW-1:0]);
         chk("tlast", tlast, m_out[DATAW]);
      end
      if (stall) chk("stable", tdata, pre);
      chk("occ", occ, mq.size());
      chk("ready", client_ready, mq.size() < DEPTH);
      chk("beats", beat_count, m_beats);
      chk("pkts", pkt_count, m_pkts);
   endtask

   task automatic drain();
      int n;
      client_valid = 1'b0;
      tready = 1'b1;
      n = 0;
      while ((m_valid || mq.size() > 0) && n < 60) begin
         cycle();
         n++;
      end
      chk("drain_done", m_valid || mq.size() > 0, 1'b0);
   endtask

   initial begin
      logic [7:0]      w;
      logic [CNTW-1:0] b0;
      int              sent, cyc;
      // 1: reset state
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_ready", client_ready, 1'b1);
      chk("rst_occ", occ, 0);
      chk("rst_beats", beat_count, 0);
      chk("rst_pkts", pkt_count, 0);

      // 2: basic 3-word packet
      tready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         client_valid = 1'b1;
         client_tdata = DATAW'(i);
         client_tlast = (i == 3);
         cycle();
      end
      drain();
      chk("t2_beats", beat_count, 3);
      chk("t2_pkts", pkt_count, 1);

      // 3: full backpressure
      tready = 1'b0;
      w = 8'h10;
      for (int i = 0; i < 20; i++) begin
         client_valid = 1'b1;
         client_tdata = DATAW'(w);
         client_tlast = 1'b0;
         cycle();
         if (accepted) w++;
      end
      chk("t3_accepted", w, 8'h21);
      chk("t3_occ", occ, 16);
      chk("t3_ready", client_ready, 1'b0);
      chk("t3_head", tdata, 8'h10);
      tready = 1'b1;
      cyc = 0;
      while (w <= 8'h21 && cyc < 40) begin
         client_tdata = DATAW'(w);
         client_tlast = (w == 8'h21);
         cycle();
         if (accepted) w++;
         cyc++;
      end
      drain();
      chk("t3_beats", beat_count, 21);
      chk("t3_pkts", pkt_count, 2);

      // 4: steady state with 5 buffered
      tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         client_valid = 1'b1;
         client_tdata = rnd128();
         client_tlast = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("t4_occ0", occ, 5);
      b0 = beat_count;
      tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         client_tdata = rnd128();
         client_tlast = 1'($urandom_range(0, 1));
         cycle();
         chk("t4_occ", occ, 5);
      end
      chk("t4_beats", beat_count - b0, 20);
      drain();

      // 5: random tready over 100 words
      b0 = beat_count;
      sent = 0;
      cyc = 0;
      client_tdata = rnd128();
      client_tlast = 1'($urandom_range(0, 1));
      while ((sent < 100 || m_valid || mq.size() > 0) && cyc < 3000) begin
         client_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
         tready = 1'($urandom_range(0, 1));
         cycle();
         if (accepted) begin
            sent++;
            client_tdata = rnd128();
            client_tlast = 1'($urandom_range(0, 1));
         end
         cyc++;
      end
      chk("t5_finished", cyc < 3000, 1'b1);
      chk("t5_beats", beat_count - b0, 100);

      // 6: reset mid-stream with 8 words pending
      tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         client_valid = 1'b1;
         client_tdata = rnd128();
         client_tlast = 1'b1;
         cycle();
      end
      client_valid = 1'b0;
      chk("t6_pending", occ, 7);
      #1 rst = 1'b0;
      #1;
      chk("t6_tvalid", tvalid, 1'b0);
      chk("t6_occ", occ, 0);
      chk("t6_beats", beat_count, 0);
      mq.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_beats = '0;
      m_pkts  = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tready = 1'b1;
      client_valid = 1'b1;
      client_tdata = DATAW'(8'hAA);
      client_tlast = 1'b1;
      cycle();
      client_valid = 1'b0;
      cycle();
      chk("t6_first", tdata, 8'hAA);
      drain();
      chk("t6_beat1", beat_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_client.md
# adder_client

Upstream traffic source for the `adder` block. Accepts operand words from a local producer through a valid/ready push port and buffers them in a FIFO. Replays them as an AXI-Stream master into the adder's `axis_adder_interface_*` slave port, preserving `tlast` per beat. Also counts accepted beats and packets for test and debug.

## Interface

- `DATAW`, 128, operand width in bits; matches the adder's tdata width.
- `FIFO_DEPTH`, 16, buffer entries; power of two, ≥2.
- `CNTW`, 32, width of the beat and packet counters.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0).
- `client_tdata`  in  DATAW  operand word from the producer.
- `client_tlast`  in  1  marks the last operand of a sum.
- `client_valid`  in  1  producer has a word.
- `client_ready`  out  1  block can accept a word this cycle.
- `axis_adder_interface_tvalid`  out  1  beat valid toward the adder.
- `axis_adder_interface_tlast`  out  1  last beat of packet.
- `axis_adder_interface_tdata`  out  DATAW  beat payload.
- `axis_adder_interface_tready`  in  1  adder accepts the beat.
- `fifo_occupancy`  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO (excludes output register).
- `beat_count`  out  CNTW  beats accepted by the adder.
- `pkt_count`  out  CNTW  beats with tlast accepted by the adder.

## Operation

- **Push.** Occurs when `client_valid && client_ready`. Writes {`client_tlast`, `client_tdata`} at the write pointer.
- **client_ready.** Equals `fifo_occupancy < FIFO_DEPTH`, computed from registered state only. A full FIFO refuses a push even if a pop happens the same cycle.
- **Pointers.** Read and write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Empty when pointers are equal; full when the MSBs differ and the remaining bits are equal.
- **Output stage.** A single output register holds {tlast, tdata} and drives the AXI-S outputs. It is controlled by a 2-state FSM:
  - **IDLE** (output register empty, tvalid=0):
    - FIFO non-empty → load head, pop, go to **SEND**.
  - **SEND** (tvalid=1):
    - tready=1 and FIFO non-empty → load next head, pop, stay in SEND (back-to-back beats).
    - tready=1 and FIFO empty → go to IDLE.
    - tready=0 → hold tdata, tlast and tvalid stable. This is mandatory AXI-S behaviour; tvalid is never retracted without a handshake.
- **No bypass.** A word pushed into an empty FIFO always passes through the FIFO.
- **Simultaneous push and pop.** Occupancy is unchanged; both pointers advance.
- **Counters.**
  - `beat_count` increments on each tvalid && tready.
  - `pkt_count` increments when that beat also has tlast=1.
  - Both wrap modulo 2^CNTW with no saturation.
- **tlast.** Passed through unmodified. The block does not check packet structure.

## Timing

- **Reset values** (while rst=0, taking effect immediately and asynchronously):
  - tvalid=0, tlast=0, tdata=0.
  - fifo_occupancy=0, beat_count=0, pkt_count=0.
  - FSM=IDLE, pointers=0.
  - client_ready=1 (derived from occupancy 0).
- **Reset mid-stream.** Pending FIFO contents and the output beat are discarded. After release, nothing stale is emitted. The first push after release is the first beat out.
- **Latency.** A word pushed at edge N into an empty block (FIFO empty, FSM in IDLE) is loaded into the output register at edge N+1, so tvalid is high from just after N+1. The adder accepts it at the first edge ≥N+2 with tready=1.
- **Throughput.** One beat per cycle when client_valid=1 and tready=1 continuously.
- **Capacity.** FIFO_DEPTH words in the FIFO plus 1 in the output register, FIFO_DEPTH+1 in total.
- **client_ready deassertion.** Drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.
- **Ordering.** Beat order out equals push order in, under any tready pattern.

## Test plan

1. **Reset state.** Hold rst=0 for 2 cycles, then release → tvalid=0, client_ready=1, fifo_occupancy=0, beat_count=0, pkt_count=0.
2. **Basic 3-word packet.** Push 0x1, 0x2, 0x3 on consecutive cycles, tlast on 0x3, tready=1 → adder sees 0x1, 0x2, 0x3 on 3 consecutive cycles. tvalid rises one cycle after the first push edge. tlast=1 only with 0x3. End state: beat_count=3, pkt_count=1.
3. **Full backpressure.** tready=0 and push 0x10..0x21 every cycle → exactly 17 words accepted (0x10 in the output register, 16 in the FIFO). Then client_ready=0 and fifo_occupancy=16, and tdata stays at 0x10 throughout. Release tready → 17 beats emerge in order, ending with 0x20. The 0x21 push is retried and accepted when ready returns, so 18 beats total.
4. **Steady state with 5 buffered.** With 5 words buffered, push and pop every cycle with tready=1 for 20 cycles → fifo_occupancy stays at 5 and beat_count advances by 20.
5. **Random tready, data preserved.** Toggle tready with a random pattern over 100 pushed words → output sequence matches pushed sequence, tdata is stable whenever tvalid=1 and tready=0, and beat_count=100.
6. **Reset mid-stream.** Assert rst=0 asynchronously between edges with 8 words pending → tvalid=0 immediately and fifo_occupancy=0. Release, then push 0xAA → the next beat out is 0xAA with beat_count=1.
